// File: rtl/uart_tx_fifo_if.sv
// Producer-side and line-side signals of the buffered UART transmitter.
// master: the word producer / observer; slave: the transmitter itself.
interface uart_tx_fifo_if #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16
);
   logic [DATA_BITS-1:0]         data_in;
   logic                         wr_en;
   logic                         full;
   logic [$clog2(FIFO_DEPTH):0]  fifo_count;
   logic                         overflow;
   logic                         tx;
   logic                         tx_busy;

   modport master (
      output data_in, wr_en,
      input  full, fifo_count, overflow, tx, tx_busy
   );

   modport slave (
      input  data_in, wr_en,
      output full, fifo_count, overflow, tx, tx_busy
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO of words, LSB-first frames; parity bit when UART_TX_PARITY_EN is defined.
// Latency: write at edge N into idle block -> tx falls at edge N+1; frames back-to-back with no idle bit.
// Backpressure: full flags FIFO_DEPTH queued words; writes while full are dropped and pulse overflow.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 16,
   parameter int PARITY_ODD   = 0
) (
   input  logic          clk,
   input  logic          reset_n,
   uart_tx_fifo_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = 3;

`ifdef UART_TX_PARITY_EN
   localparam logic PAR_ODD = (PARITY_ODD != 0);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state, state_nxt;
   logic [BW-1:0]        baud, baud_nxt;
   logic [IW-1:0]        bit_idx, bit_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 tx_q, tx_nxt;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count, count_nxt;
   logic                 full_q, overflow_q;
   logic                 push, pop, tc, not_empty;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_nxt;
`endif

   // full is the registered state, so a pop in the same cycle never rescues a write
   assign push      = bus.wr_en && !full_q;
   assign not_empty = (count != '0);
   assign tc        = (baud == BW'(CLKS_PER_BIT - 1));
   assign count_nxt = count + CW'(push) - CW'(pop);

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud + 1'b1;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      pop       = 1'b0;
      tx_nxt    = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_nxt   = par_q;
`endif
      case (state)
         IDLE: begin
            baud_nxt = '0;
            if (not_empty) begin
               pop       = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            if (tc) begin
               state_nxt = DATA;
               baud_nxt  = '0;
               bit_nxt   = '0;
            end
         end
         DATA: begin
            if (tc) begin
               baud_nxt  = '0;
               shreg_nxt = shreg >> 1;
               if (bit_idx == IW'(DATA_BITS - 1)) begin
                  bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  bit_nxt = bit_idx + 1'b1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tc) begin
               state_nxt = STOP;
               baud_nxt  = '0;
               bit_nxt   = '0;
            end
         end
`endif
         STOP: begin
            if (tc) begin
               baud_nxt = '0;
               if (bit_idx == IW'(STOP_BITS - 1)) begin
                  bit_nxt = '0;
                  // chain straight into the next start bit when more words wait
                  if (not_empty) begin
                     pop       = 1'b1;
                     state_nxt = START;
                  end else begin
                     state_nxt = IDLE;
                  end
               end else begin
                  bit_nxt = bit_idx + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (pop) begin
         shreg_nxt = mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
         par_nxt   = (^mem[rd_ptr]) ^ PAR_ODD;
`endif
      end

      // line level is decoded from the next state so tx itself is a flop
      case (state_nxt)
         START:   tx_nxt = 1'b0;
         DATA:    tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_nxt = par_nxt;
`endif
         default: tx_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         baud       <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         tx_q       <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         state      <= state_nxt;
         baud       <= baud_nxt;
         bit_idx    <= bit_nxt;
         shreg      <= shreg_nxt;
         tx_q       <= tx_nxt;
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         count      <= count_nxt;
         full_q     <= (count_nxt == CW'(FIFO_DEPTH));
         overflow_q <= bus.wr_en && full_q;
`ifdef UART_TX_PARITY_EN
         par_q      <= par_nxt;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= bus.data_in;
      end
   end

   assign bus.tx         = tx_q;
   assign bus.full       = full_q;
   assign bus.fifo_count = count;
   assign bus.overflow   = overflow_q;
   assign bus.tx_busy    = (state != IDLE) || not_empty;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-of-line-levels model compared every cycle, plus directed literal checks.
module tb_uart_tx_fifo;
   localparam int CPB = 4, DB = 8, SB = 1, DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P      = 1;
   localparam int LIT_F  = 44;
   localparam int LIT_F2 = 48;
   localparam logic [15:0] LIT_PAT = 16'h02A9;
`else
   localparam int P      = 0;
   localparam int LIT_F  = 40;
   localparam int LIT_F2 = 44;
   localparam logic [15:0] LIT_PAT = 16'h0155;
`endif
   localparam int NBITS = 1 + DB + P + SB;
   localparam int F     = NBITS * CPB;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chk_en = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus ();
   uart_tx_fifo_if #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH)) bus2 ();

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(SB),
                  .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus.slave));

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .STOP_BITS(2),
                  .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) dut2 (
      .clk(clk), .reset_n(reset_n), .bus(bus2.slave));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: queued words plus the list of line levels still to be driven, one entry per cycle.
   int fq[$];
   bit lq[$];
   bit m_tx = 1'b1;
   bit m_active = 1'b0;
   bit m_ovf = 1'b0;

   function automatic void add_bit(input bit v, input int n);
      for (int k = 0; k < n; k++) lq.push_back(v);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fq.delete();
         lq.delete();
         m_tx = 1'b1;
         m_active = 1'b0;
         m_ovf = 1'b0;
      end else begin
         bit was_full;
         int w;
         was_full = (fq.size() == DEPTH);
         if (lq.size() == 0 && fq.size() != 0) begin
            w = fq.pop_front();
            add_bit(1'b0, CPB);
            for (int b = 0; b < DB; b++) add_bit(w[b], CPB);
`ifdef UART_TX_PARITY_EN
            add_bit(^w[DB-1:0], CPB);
`endif
            add_bit(1'b1, SB * CPB);
         end
         if (lq.size() != 0) begin
            m_tx = lq.pop_front();
            m_active = 1'b1;
         end else begin
            m_tx = 1'b1;
            m_active = 1'b0;
         end
         m_ovf = bus.wr_en && was_full;
         if (bus.wr_en && !was_full) fq.push_back(int'(bus.data_in));
      end
   end

   always @(negedge clk) begin
      if (chk_en && reset_n) begin
         chk("model_tx", bus.tx, m_tx);
         chk("model_busy", bus.tx_busy, m_active || (fq.size() != 0));
         chk("model_count", bus.fifo_count, fq.size());
         chk("model_full", bus.full, fq.size() == DEPTH);
         chk("model_overflow", bus.overflow, m_ovf);
      end
   end

   task automatic decode(output logic [7:0] d, output int t, output logic par_bit);
      int n = 0;
      d = '0;
      while (bus.tx !== 1'b0 && n < 4 * F) begin
         @(negedge clk);
         n++;
      end
      if (bus.tx !== 1'b0) chk("decode_timeout", bus.tx, 0);
      t = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int b = 0; b < DB; b++) begin
         repeat (CPB) @(negedge clk);
         d[b] = bus.tx;
      end
      par_bit = 1'b0;
      if (P != 0) begin
         repeat (CPB) @(negedge clk);
         par_bit = bus.tx;
      end
      repeat (CPB) @(negedge clk);
      chk("stop_level", bus.tx, 1);
   endtask

   task automatic wait_idle(input bit second, output int t);
      int n = 0;
      while ((second ? bus2.tx_busy : bus.tx_busy) && n < 6 * F) begin
         @(negedge clk);
         n++;
      end
      if (second ? bus2.tx_busy : bus.tx_busy) chk("idle_timeout", 1, 0);
      t = cyc;
   endtask

   task automatic wait_tx2(input logic lvl, output int t);
      int n = 0;
      while (bus2.tx !== lvl && n < 4 * F) begin
         @(negedge clk);
         n++;
      end
      if (bus2.tx !== lvl) chk("tx2_timeout", bus2.tx, lvl);
      t = cyc;
   endtask

   initial begin
      logic [15:0] got;
      logic [7:0]  d1, d2;
      logic        pb, cur, stable;
      int          t1, t2, tr, tw1, tend;
      bus.wr_en = 1'b0;  bus.data_in = '0;
      bus2.wr_en = 1'b0; bus2.data_in = '0;

      repeat (5) @(negedge clk);
      chk("rst_tx", bus.tx, 1);
      chk("rst_busy", bus.tx_busy, 0);
      chk("rst_count", bus.fifo_count, 0);
      chk("rst_full", bus.full, 0);
      chk("rst_overflow", bus.overflow, 0);
      reset_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      // single frame
      bus.data_in = 8'h55; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      chk("lat_count1", bus.fifo_count, 1);
      chk("lat_tx_idle", bus.tx, 1);
      @(negedge clk);
      chk("lat_tx_fall", bus.tx, 0);
      chk("lat_count0", bus.fifo_count, 0);
      got = '0; stable = 1'b1; cur = 1'b0;
      for (int i = 0; i < F; i++) begin
         if (i > 0) @(negedge clk);
         if (i % CPB == 0) begin
            cur = bus.tx;
            got[NBITS - 1 - i / CPB] = bus.tx;
         end else if (bus.tx !== cur) begin
            stable = 1'b0;
         end
      end
      chk("single_pattern", got, LIT_PAT);
      chk("single_stable", stable, 1);
      chk("busy_last_stop", bus.tx_busy, 1);
      @(negedge clk);
      chk("busy_drop", bus.tx_busy, 0);

      // back-to-back frames
      bus.data_in = 8'hA5; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.data_in = 8'h3C;
      @(negedge clk);
      bus.wr_en = 1'b0;
      decode(d1, t1, pb);
      decode(d2, t2, pb);
      chk("b2b_byte0", d1, 8'hA5);
      chk("b2b_byte1", d2, 8'h3C);
      chk("b2b_period", t2 - t1, LIT_F);
      wait_idle(1'b0, tend);

      // fill to full, one dropped write
      for (int i = 0; i < 6; i++) begin
         bus.data_in = 8'h10 + 8'(i); bus.wr_en = 1'b1;
         @(negedge clk);
         if (i == 0) tw1 = cyc;
         if (i == 3) chk("full_before", bus.full, 0);
         if (i == 4) chk("full_rise", bus.full, 1);
         if (i == 5) begin
            chk("ovf_pulse", bus.overflow, 1);
            chk("ovf_count", bus.fifo_count, 4);
         end
      end
      bus.wr_en = 1'b0;
      @(negedge clk);
      chk("ovf_end", bus.overflow, 0);
      chk("full_hold_count", bus.fifo_count, 4);
      wait_idle(1'b0, tend);
      chk("burst_len_5_frames", tend - tw1, 1 + 5 * LIT_F);

      // reset in the middle of a frame
      bus.data_in = 8'h00; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.data_in = 8'h81;
      @(negedge clk);
      bus.wr_en = 1'b0;
      repeat (10) @(negedge clk);
      chk("pre_reset_tx", bus.tx, 0);
      chk("pre_reset_count", bus.fifo_count, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_reset_tx", bus.tx, 1);
      chk("mid_reset_count", bus.fifo_count, 0);
      chk("mid_reset_busy", bus.tx_busy, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_tx", bus.tx, 1);
      chk("post_reset_busy", bus.tx_busy, 0);

      // two stop bits
      bus2.data_in = 8'hFF; bus2.wr_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus2.wr_en = 1'b0;
      wait_tx2(1'b0, t1);
      wait_tx2(1'b1, tr);
      wait_tx2(1'b0, t2);
      chk("stop2_start_len", tr - t1, CPB);
      chk("stop2_period", t2 - t1, LIT_F2);
      chk("stop2_high_run", t2 - tr, LIT_F2 - 4);
      wait_idle(1'b1, tend);
      chk("stop2_last_frame", tend - t2, LIT_F2);

`ifdef UART_TX_PARITY_EN
      // parity of 0x07: even -> 1, odd -> 0
      bus.data_in = 8'h07; bus.wr_en = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      decode(d1, t1, pb);
      chk("par_even_data", d1, 8'h07);
      chk("par_even_bit", pb, 1);
      wait_idle(1'b0, tend);
      bus2.data_in = 8'h07; bus2.wr_en = 1'b1;
      @(negedge clk);
      bus2.wr_en = 1'b0;
      wait_tx2(1'b0, t1);
      repeat (CPB / 2 + 9 * CPB) @(negedge clk);
      chk("par_odd_bit", bus2.tx, 0);
      wait_idle(1'b1, tend);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
